// File: rtl/mem_controller.sv
// Byte-serial memory arbiter between the load/store buffer, the instruction fetcher
// and the 8-bit RAM/IO bus. One word/half/byte transaction is sequenced at a time.
module mem_controller #(
    parameter bit       LSB_PRIORITY = 1'b1,
    parameter bit [1:0] IO_TAG       = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _if_mem_ready,
    input  logic [31:0] _if_addr,
    output logic        _mem_if_ready,
    output logic [31:0] _mem_if_data,
    input  logic        _lsb_mem_ready,
    input  logic [1:0]  _work_type,
    input  logic        _r_nw_in,
    input  logic [31:0] _addr,
    input  logic [31:0] _data_in,
    output logic        _mem_busy,
    output logic        _mem_lsb_ready,
    output logic [31:0] _data_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [31:0] r_wdata;
    logic        r_isLsb;
    logic [31:0] r_rdata;
    logic        r_lsbReady;
    logic        r_ifReady;
    logic [31:0] r_dataOut;
    logic [31:0] r_ifData;

    state_t      w_stateNext;
    logic [2:0]  w_cntNext;
    logic [31:0] w_addrNext;
    logic [2:0]  w_sizeNext;
    logic [31:0] w_wdataNext;
    logic        w_isLsbNext;
    logic [31:0] w_rdataNext;
    logic        w_lsbReadyNext;
    logic        w_ifReadyNext;
    logic [31:0] w_dataOutNext;
    logic [31:0] w_ifDataNext;

    logic        w_lsbWins;
    logic        w_ifWins;
    logic [2:0]  w_reqSize;
    logic        w_stall;
    logic        w_active;
    logic [1:0]  w_capIdx;
    logic [31:0] w_captured;

    assign w_lsbWins = _lsb_mem_ready && (LSB_PRIORITY || !_if_mem_ready);
    assign w_ifWins  = _if_mem_ready && !w_lsbWins;
    assign w_stall   = (r_state == WRITE) && (r_addr[17:16] == IO_TAG) && io_buffer_full;
    assign w_capIdx  = r_cnt[1:0] - 2'd1;

    always_comb begin
        w_reqSize = 3'd4;
        case (_work_type)
            2'b00:   w_reqSize = 3'd1;
            2'b01:   w_reqSize = 3'd2;
            default: w_reqSize = 3'd4;
        endcase
    end

    // The byte arriving now belongs to the address presented one cycle earlier.
    always_comb begin
        w_captured = r_rdata;
        if (r_cnt != 3'd0) begin
            w_captured[{w_capIdx, 3'b000} +: 8] = mem_din;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_addrNext     = r_addr;
        w_sizeNext     = r_size;
        w_wdataNext    = r_wdata;
        w_isLsbNext    = r_isLsb;
        w_rdataNext    = r_rdata;
        w_lsbReadyNext = 1'b0;
        w_ifReadyNext  = 1'b0;
        w_dataOutNext  = r_dataOut;
        w_ifDataNext   = r_ifData;

        case (r_state)
            IDLE: begin
                if (!_clear && (w_lsbWins || w_ifWins)) begin
                    w_cntNext   = 3'd0;
                    w_rdataNext = '0;
                    w_isLsbNext = w_lsbWins;
                    if (w_lsbWins) begin
                        w_addrNext  = _addr;
                        w_sizeNext  = w_reqSize;
                        w_wdataNext = _data_in;
                        w_stateNext = _r_nw_in ? READ : WRITE;
                    end else begin
                        w_addrNext  = _if_addr;
                        w_sizeNext  = 3'd4;
                        w_wdataNext = '0;
                        w_stateNext = READ;
                    end
                end
            end
            READ: begin
                // A flush drops any partial load or fetch, even on its final capture.
                if (_clear) begin
                    w_stateNext = IDLE;
                    w_cntNext   = 3'd0;
                    w_rdataNext = '0;
                end else if (r_cnt == r_size) begin
                    w_stateNext = IDLE;
                    w_cntNext   = 3'd0;
                    w_rdataNext = '0;
                    if (r_isLsb) begin
                        w_lsbReadyNext = 1'b1;
                        w_dataOutNext  = w_captured;
                    end else begin
                        w_ifReadyNext = 1'b1;
                        w_ifDataNext  = w_captured;
                    end
                end else begin
                    w_cntNext   = r_cnt + 3'd1;
                    w_rdataNext = w_captured;
                end
            end
            WRITE: begin
                if (!w_stall) begin
                    if (r_cnt == r_size - 3'd1) begin
                        w_stateNext    = IDLE;
                        w_cntNext      = 3'd0;
                        w_lsbReadyNext = 1'b1;
                    end else begin
                        w_cntNext = r_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = 3'd0;
            end
        endcase
    end

    // Everything freezes while rdy_in is low, including a pending completion pulse.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_addr     <= '0;
            r_size     <= 3'd0;
            r_wdata    <= '0;
            r_isLsb    <= 1'b0;
            r_rdata    <= '0;
            r_lsbReady <= 1'b0;
            r_ifReady  <= 1'b0;
            r_dataOut  <= '0;
            r_ifData   <= '0;
        end else if (rdy_in) begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_addr     <= w_addrNext;
            r_size     <= w_sizeNext;
            r_wdata    <= w_wdataNext;
            r_isLsb    <= w_isLsbNext;
            r_rdata    <= w_rdataNext;
            r_lsbReady <= w_lsbReadyNext;
            r_ifReady  <= w_ifReadyNext;
            r_dataOut  <= w_dataOutNext;
            r_ifData   <= w_ifDataNext;
        end
    end

    assign w_active = (r_state == WRITE) || ((r_state == READ) && (r_cnt < r_size));

    assign _mem_busy      = (r_state != IDLE);
    assign mem_a          = w_active ? (r_addr + {30'd0, r_cnt[1:0]}) : '0;
    assign mem_dout       = (r_state == WRITE) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : '0;
    assign mem_wr         = (r_state == WRITE) && !w_stall && rdy_in;
    assign _mem_lsb_ready = r_lsbReady && rdy_in;
    assign _mem_if_ready  = r_ifReady && rdy_in;
    assign _data_out      = r_dataOut;
    assign _mem_if_data   = r_ifData;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: a small byte RAM answers reads one cycle late,
// and every check compares against hand-computed values.
module tb_mem_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _if_mem_ready;
    logic [31:0] _if_addr;
    logic        _mem_if_ready;
    logic [31:0] _mem_if_data;
    logic        _lsb_mem_ready;
    logic [1:0]  _work_type;
    logic        _r_nw_in;
    logic [31:0] _addr;
    logic [31:0] _data_in;
    logic        _mem_busy;
    logic        _mem_lsb_ready;
    logic [31:0] _data_out;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int vecCount  = 0;
    int missCount = 0;
    int lsbPulses = 0;
    int ifPulses  = 0;
    int bothHigh  = 0;

    logic [7:0] ram [0:4095];

    always #5 clk_in = ~clk_in;

    mem_controller dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._if_mem_ready  (_if_mem_ready),
        ._if_addr       (_if_addr),
        ._mem_if_ready  (_mem_if_ready),
        ._mem_if_data   (_mem_if_data),
        ._lsb_mem_ready (_lsb_mem_ready),
        ._work_type     (_work_type),
        ._r_nw_in       (_r_nw_in),
        ._addr          (_addr),
        ._data_in       (_data_in),
        ._mem_busy      (_mem_busy),
        ._mem_lsb_ready (_mem_lsb_ready),
        ._data_out      (_data_out),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    // Folds the few address regions the bench touches into a small array.
    function automatic logic [11:0] ramIdx(input logic [31:0] a);
        return {a[17:16], a[9:0]};
    endfunction

    always @(posedge clk_in) begin
        mem_din <= ram[ramIdx(mem_a)];
    end

    always @(negedge clk_in) begin
        if (_mem_lsb_ready) lsbPulses++;
        if (_mem_if_ready) ifPulses++;
        if (_mem_lsb_ready && _mem_if_ready) bothHigh++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lsbReq, input logic ifReq, input logic [1:0] workType,
                                 input logic rnw, input logic [31:0] addr, input logic [31:0] ifAddr,
                                 input logic [31:0] data);
        _lsb_mem_ready = lsbReq;
        _if_mem_ready  = ifReq;
        _work_type     = workType;
        _r_nw_in       = rnw;
        _addr          = addr;
        _if_addr       = ifAddr;
        _data_in       = data;
    endtask

    task automatic nextCycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        int snapLsb;
        int snapIf;
        logic [31:0] storeWord;

        for (int k = 0; k < 4096; k++) ram[k] = 8'h00;
        ram[ramIdx(32'h100)] = 8'h11;
        ram[ramIdx(32'h101)] = 8'h22;
        ram[ramIdx(32'h102)] = 8'h33;
        ram[ramIdx(32'h103)] = 8'h44;
        ram[ramIdx(32'h200)] = 8'hCD;
        ram[ramIdx(32'h201)] = 8'hAB;
        ram[ramIdx(32'h202)] = 8'h77;
        ram[ramIdx(32'h203)] = 8'h66;
        ram[ramIdx(32'h000)] = 8'h01;
        ram[ramIdx(32'h001)] = 8'h02;
        ram[ramIdx(32'h002)] = 8'h03;
        ram[ramIdx(32'h003)] = 8'h04;

        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        _clear         = 1'b0;
        io_buffer_full = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);

        #2;
        checkOutput("rst_busy", 32'(_mem_busy), 32'h0);
        checkOutput("rst_mem_a", mem_a, 32'h0);
        checkOutput("rst_mem_wr", 32'(mem_wr), 32'h0);
        checkOutput("rst_lsb_ready", 32'(_mem_lsb_ready), 32'h0);
        checkOutput("rst_if_ready", 32'(_mem_if_ready), 32'h0);
        checkOutput("rst_data_out", _data_out, 32'h0);
        nextCycle();
        nextCycle();
        rst_in = 1'b1;
        nextCycle();

        $display("[TB] word load at 0x100");
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        settle();
        checkOutput("ld_busy", 32'(_mem_busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                nextCycle();
                settle();
            end
            checkOutput($sformatf("ld_addr%0d", i), mem_a, 32'h100 + 32'(i));
            checkOutput($sformatf("ld_wr%0d", i), 32'(mem_wr), 32'h0);
        end
        nextCycle();
        settle();
        checkOutput("ld_early_ready", 32'(_mem_lsb_ready), 32'h0);
        checkOutput("ld_idle_addr", mem_a, 32'h0);
        nextCycle();
        settle();
        checkOutput("ld_ready", 32'(_mem_lsb_ready), 32'h1);
        checkOutput("ld_data", _data_out, 32'h44332211);
        checkOutput("ld_done_busy", 32'(_mem_busy), 32'h0);
        nextCycle();
        settle();
        checkOutput("ld_ready_drop", 32'(_mem_lsb_ready), 32'h0);
        checkOutput("ld_data_hold", _data_out, 32'h44332211);

        $display("[TB] simultaneous half load and fetch");
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 32'h200, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        settle();
        checkOutput("arb_addr0", mem_a, 32'h200);
        nextCycle();
        settle();
        checkOutput("arb_addr1", mem_a, 32'h201);
        nextCycle();
        settle();
        checkOutput("arb_early_ready", 32'(_mem_lsb_ready), 32'h0);
        nextCycle();
        settle();
        checkOutput("arb_ld_ready", 32'(_mem_lsb_ready), 32'h1);
        checkOutput("arb_ld_data", _data_out, 32'h0000ABCD);
        checkOutput("arb_if_quiet", 32'(_mem_if_ready), 32'h0);
        checkOutput("arb_pulse_busy", 32'(_mem_busy), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        settle();
        checkOutput("arb_fetch_busy", 32'(_mem_busy), 32'h1);
        checkOutput("arb_fetch_addr0", mem_a, 32'h0);
        repeat (4) nextCycle();
        settle();
        checkOutput("arb_if_early", 32'(_mem_if_ready), 32'h0);
        nextCycle();
        settle();
        checkOutput("arb_if_ready", 32'(_mem_if_ready), 32'h1);
        checkOutput("arb_if_data", _mem_if_data, 32'h04030201);
        checkOutput("arb_lsb_quiet", 32'(_mem_lsb_ready), 32'h0);
        nextCycle();
        settle();
        checkOutput("arb_if_drop", 32'(_mem_if_ready), 32'h0);

        $display("[TB] IO byte store under back-pressure");
        io_buffer_full = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h30000, 32'h0, 32'hFFFFFFA5);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        settle();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                nextCycle();
                settle();
            end
            checkOutput($sformatf("io_stall_wr%0d", k), 32'(mem_wr), 32'h0);
            checkOutput($sformatf("io_stall_addr%0d", k), mem_a, 32'h30000);
        end
        nextCycle();
        io_buffer_full = 1'b0;
        settle();
        checkOutput("io_wr", 32'(mem_wr), 32'h1);
        checkOutput("io_dout", 32'(mem_dout), 32'hA5);
        checkOutput("io_addr", mem_a, 32'h30000);
        nextCycle();
        settle();
        checkOutput("io_ready", 32'(_mem_lsb_ready), 32'h1);
        checkOutput("io_wr_after", 32'(mem_wr), 32'h0);
        checkOutput("io_busy_after", 32'(_mem_busy), 32'h0);

        $display("[TB] flush during fetch");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        _clear = 1'b1;
        settle();
        checkOutput("clr_busy_before", 32'(_mem_busy), 32'h1);
        snapIf = ifPulses;
        nextCycle();
        _clear = 1'b0;
        settle();
        checkOutput("clr_busy_after", 32'(_mem_busy), 32'h0);
        repeat (5) nextCycle();
        settle();
        checkOutput("clr_no_if_pulse", 32'(ifPulses - snapIf), 32'h0);
        checkOutput("clr_if_data_hold", _mem_if_data, 32'h04030201);

        _clear = 1'b1;
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        nextCycle();
        _clear = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        settle();
        checkOutput("clr_blocks_accept", 32'(_mem_busy), 32'h0);

        $display("[TB] word store across a flush");
        storeWord = 32'hDEADBEEF;
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, storeWord);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nextCycle();
            if (i == 1) _clear = 1'b1;
            if (i == 2) _clear = 1'b0;
            settle();
            checkOutput($sformatf("st_wr%0d", i), 32'(mem_wr), 32'h1);
            checkOutput($sformatf("st_dout%0d", i), 32'(mem_dout), 32'(storeWord[8*i +: 8]));
            checkOutput($sformatf("st_addr%0d", i), mem_a, 32'h500 + 32'(i));
        end
        nextCycle();
        settle();
        checkOutput("st_ready", 32'(_mem_lsb_ready), 32'h1);

        $display("[TB] half store paused by rdy_in");
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h600, 32'h0, 32'h00001234);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        settle();
        checkOutput("rdy_wr0", 32'(mem_wr), 32'h1);
        checkOutput("rdy_dout0", 32'(mem_dout), 32'h34);
        checkOutput("rdy_addr0", mem_a, 32'h600);
        nextCycle();
        rdy_in = 1'b0;
        settle();
        checkOutput("rdy_hold_wr1", 32'(mem_wr), 32'h0);
        checkOutput("rdy_hold_addr1", mem_a, 32'h601);
        nextCycle();
        settle();
        checkOutput("rdy_hold_wr2", 32'(mem_wr), 32'h0);
        checkOutput("rdy_hold_addr2", mem_a, 32'h601);
        checkOutput("rdy_hold_ready", 32'(_mem_lsb_ready), 32'h0);
        nextCycle();
        rdy_in = 1'b1;
        settle();
        checkOutput("rdy_wr1", 32'(mem_wr), 32'h1);
        checkOutput("rdy_dout1", 32'(mem_dout), 32'h12);
        checkOutput("rdy_addr1", mem_a, 32'h601);
        nextCycle();
        settle();
        checkOutput("rdy_ready", 32'(_mem_lsb_ready), 32'h1);

        $display("[TB] reset in the middle of a word load");
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        rst_in = 1'b0;
        settle();
        checkOutput("mid_rst_busy", 32'(_mem_busy), 32'h0);
        checkOutput("mid_rst_mem_a", mem_a, 32'h0);
        checkOutput("mid_rst_data_out", _data_out, 32'h0);
        checkOutput("mid_rst_if_data", _mem_if_data, 32'h0);
        nextCycle();
        rst_in = 1'b1;
        snapLsb = lsbPulses;
        repeat (6) nextCycle();
        settle();
        checkOutput("mid_rst_no_pulse", 32'(lsbPulses - snapLsb), 32'h0);
        checkOutput("mid_rst_idle", 32'(_mem_busy), 32'h0);

        checkOutput("ready_exclusive", 32'(bothHigh), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
